// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control bundle layout, ALUOp encodings, register specifiers.
package mips_pkg;

    localparam int unsigned CTRL_W = 9;
    localparam int unsigned REG_W  = 5;

    // Bit positions inside the control bundle, MSB first.
    localparam int unsigned CTRL_REGDST   = 8;
    localparam int unsigned CTRL_ALUSRC   = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_REGWRITE = 5;
    localparam int unsigned CTRL_MEMREAD  = 4;
    localparam int unsigned CTRL_MEMWRITE = 3;
    localparam int unsigned CTRL_BRANCH   = 2;
    localparam int unsigned CTRL_ALUOP_HI = 1;
    localparam int unsigned CTRL_ALUOP_LO = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } regspec_t;

endpackage

// File: rtl/id_ex_slot.sv
// One ID/EX buffer entry: payload register with load enable and async active-low clear.
module id_ex_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register as a two-entry elastic buffer (output slot + skid slot).
// in_ready comes straight from the skid valid flop, so upstream never sees out_ready combinationally.
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = mips_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc4,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd
);

    localparam int unsigned PAY_W = CTRL_W + 4 * DATA_W + 3 * REG_W;

    logic out_valid_q,  out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic out_free_c, accept_c, out_ld_c, skid_ld_c;

    logic [PAY_W-1:0] in_pay_c, out_src_c, out_pay_c, skid_pay_c;
    logic [CTRL_W-1:0] out_ctrl_raw_c;
    regspec_t          in_spec_c, out_spec_c;

    assign in_spec_c = '{rs: in_rs, rt: in_rt, rd: in_rd};
    assign in_pay_c  = {in_ctrl, in_rd1, in_rd2, in_imm, in_pc4, in_spec_c};

    // Slot steering and occupancy; flush overrides every other event.
    always_comb begin
        out_free_c   = !out_valid_q || out_ready;
        accept_c     = in_valid && !skid_valid_q;
        out_ld_c     = 1'b0;
        skid_ld_c    = 1'b0;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free_c) begin
            out_ld_c     = skid_valid_q || accept_c;
            out_valid_d  = skid_valid_q || accept_c;
            skid_valid_d = 1'b0;
        end else begin
            skid_ld_c    = accept_c;
            skid_valid_d = skid_valid_q || accept_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // The skid entry is older than anything arriving, so it refills the output slot first.
    assign out_src_c = skid_valid_q ? skid_pay_c : in_pay_c;

    id_ex_slot #(.W(PAY_W)) u_out_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (out_ld_c),
        .d_i   (out_src_c),
        .q_o   (out_pay_c)
    );

    id_ex_slot #(.W(PAY_W)) u_skid_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (skid_ld_c),
        .d_i   (in_pay_c),
        .q_o   (skid_pay_c)
    );

    assign {out_ctrl_raw_c, out_rd1, out_rd2, out_imm, out_pc4, out_spec_c} = out_pay_c;

    // A bubble must carry no control side effects downstream.
    assign out_ctrl  = out_valid_q ? out_ctrl_raw_c : '0;
    assign out_rs    = out_spec_c.rs;
    assign out_rt    = out_spec_c.rt;
    assign out_rd    = out_spec_c.rd;
    assign out_valid = out_valid_q;
    assign in_ready  = !skid_valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed and random scoreboard bench for the ID/EX elastic pipeline register.
module tb_id_ex_reg;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_ctrl;
    logic [31:0] in_rd1, in_rd2, in_imm, in_pc4;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_ctrl;
    logic [31:0] out_rd1, out_rd2, out_imm, out_pc4;
    logic [4:0]  out_rs, out_rt, out_rd;

    int n_chk  = 0;
    int n_pass = 0;

    id_ex_reg #(.DATA_W(32), .CTRL_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd1    (in_rd1),
        .in_rd2    (in_rd2),
        .in_imm    (in_imm),
        .in_pc4    (in_pc4),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rd1   (out_rd1),
        .out_rd2   (out_rd2),
        .out_imm   (out_imm),
        .out_pc4   (out_pc4),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .out_rd    (out_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic entry_t mk(input int k);
        entry_t     e;
        logic [15:0] kk;
        kk    = 16'(k * 977 + 1);
        e.ctrl = 9'(k * 37 + 5);
        e.rd1  = 32'hA500_0000 ^ 32'(k);
        e.rd2  = 32'h5A00_0000 + 32'(k * 3);
        e.imm  = {{16{kk[15]}}, kk};
        e.pc4  = 32'h0040_0000 + 32'(k * 4);
        e.rs   = 5'(k);
        e.rt   = 5'(k + 7);
        e.rd   = 5'(k * 3);
        return e;
    endfunction

    task automatic drive(input entry_t e);
        in_valid = 1'b1;
        in_ctrl  = e.ctrl;
        in_rd1   = e.rd1;
        in_rd2   = e.rd2;
        in_imm   = e.imm;
        in_pc4   = e.pc4;
        in_rs    = e.rs;
        in_rt    = e.rt;
        in_rd    = e.rd;
    endtask

    task automatic check_out(input string tag, input entry_t e);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_ctrl"},  64'(out_ctrl),  64'(e.ctrl));
        chk({tag, "_rd1"},   64'(out_rd1),   64'(e.rd1));
        chk({tag, "_rd2"},   64'(out_rd2),   64'(e.rd2));
        chk({tag, "_imm"},   64'(out_imm),   64'(e.imm));
        chk({tag, "_pc4"},   64'(out_pc4),   64'(e.pc4));
        chk({tag, "_regs"},  64'({out_rs, out_rt, out_rd}), 64'({e.rs, e.rt, e.rd}));
    endtask

    task automatic check_empty(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_ctrl"},  64'(out_ctrl),  64'd0);
        chk({tag, "_ready"}, 64'(in_ready),  64'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        entry_t     e;
        int         sb[$];
        int         next_id;
        logic       stall_prev;
        logic [63:0] hold_a, hold_b, hold_c;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_rd1 = '0; in_rd2 = '0; in_imm = '0; in_pc4 = '0;
        in_rs = '0; in_rt = '0; in_rd = '0;

        // Reset state
        #2;
        check_empty("rst");
        chk("rst_rd1", 64'(out_rd1), 64'd0);
        #10 rst_n = 1'b1;
        step();

        // Single entry with 1-cycle latency
        e = '{ctrl: 9'h1F0, rd1: 32'h1234_5678, rd2: 32'h8765_4321, imm: 32'hFFFF_8000,
              pc4: 32'h0040_0004, rs: 5'd3, rt: 5'd17, rd: 5'd31};
        out_ready = 1'b1;
        drive(e);
        step();
        check_out("single", e);
        in_valid = 1'b0;
        step();
        check_empty("single_after");

        // Backpressure: A then B while stalled, then release
        out_ready = 1'b0;
        drive(mk(1));
        step();
        check_out("bp_a", mk(1));
        chk("bp_ready_a", 64'(in_ready), 64'd1);
        drive(mk(2));
        step();
        chk("bp_ready_b", 64'(in_ready), 64'd0);
        check_out("bp_hold_a", mk(1));
        in_valid = 1'b0;
        step();
        check_out("bp_stall_a", mk(1));
        chk("bp_ready_stall", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check_out("bp_b", mk(2));
        chk("bp_ready_rel", 64'(in_ready), 64'd1);
        step();
        check_empty("bp_done");

        // Streaming: 8 back-to-back, no bubbles
        for (int i = 0; i < 8; i++) begin
            drive(mk(10 + i));
            step();
            check_out($sformatf("stream%0d", i), mk(10 + i));
            chk($sformatf("stream%0d_ready", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check_empty("stream_done");

        // Flush with both slots full and a pending input
        out_ready = 1'b0;
        drive(mk(20));
        step();
        drive(mk(21));
        step();
        chk("fl_full", 64'(in_ready), 64'd0);
        drive(mk(22));
        flush = 1'b1;
        step();
        check_empty("fl_both");
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check_empty("fl_both_after");

        // Flush discards a same-cycle accept
        out_ready = 1'b0;
        drive(mk(23));
        step();
        drive(mk(24));
        flush = 1'b1;
        step();
        check_empty("fl_acc");
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check_empty("fl_acc_after");

        // Asynchronous reset mid-operation, observed between clock edges
        out_ready = 1'b0;
        drive(mk(30));
        step();
        drive(mk(31));
        step();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_empty("arst");
        chk("arst_rd1", 64'(out_rd1), 64'd0);
        #1 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(mk(32));
        step();
        check_out("arst_first", mk(32));
        in_valid = 1'b0;
        step();
        check_empty("arst_done");

        // Random valid/ready scoreboard
        next_id    = 1000;
        stall_prev = 1'b0;
        hold_a = '0; hold_b = '0; hold_c = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_a", 64'({out_ctrl, out_rd1}), hold_a);
                chk("hold_b", 64'({out_imm, out_rd2}), hold_b);
                chk("hold_c", 64'({out_pc4, out_rs, out_rt, out_rd}), hold_c);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) drive(mk(next_id));
            else in_valid = 1'b0;
            if (in_valid && in_ready) begin
                sb.push_back(next_id);
                next_id++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = mk(sb.pop_front());
                    chk("sb_rd1",  64'(out_rd1),  64'(e.rd1));
                    chk("sb_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    chk("sb_imm",  64'(out_imm),  64'(e.imm));
                end
            end
            if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
            stall_prev = out_valid && !out_ready;
            hold_a = 64'({out_ctrl, out_rd1});
            hold_b = 64'({out_imm, out_rd2});
            hold_c = 64'({out_pc4, out_rs, out_rt, out_rd});
            step();
        end

        // Drain with a bounded budget
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid; i++) begin
            if (sb.size() == 0) begin
                chk("drain_underflow", 64'd1, 64'd0);
            end else begin
                e = mk(sb.pop_front());
                chk("drain_rd1", 64'(out_rd1), 64'(e.rd1));
            end
            step();
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        check_empty("drain_done");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
